serial_tx: RTL and testbench



---
 rtl/serial_pkg.sv | 18 +
 rtl/serial_tx_bit_tick_gen.sv | 40 ++++
 rtl/serial_tx.sv | 136 +++++++++++++
 tb/tb_serial_tx.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared serial-line definitions: FSM state encoding and line levels.
// Latency: n/a (definitions only).
// Backpressure: n/a; reused by the matching serial receiver.
package serial_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_tx_bit_tick_gen.sv
// Bit-period timer: pulses tick on the last clk of each CLKS_PER_BIT-cycle bit.
// Latency: tick is combinational from the counter register, asserted on terminal count.
// Backpressure: none; the counter is held at 0 while enable is low.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] TERM = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = enable && (cnt_q == TERM);

  // Count through the bit period, wrapping on terminal count; park at 0 when idle.
  always_comb begin
    cnt_d = cnt_q;
    if (!enable || tick) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_tx.sv
// Serial frame transmitter: start(0), DATA_W bits LSB first, [even parity if SERIAL_TX_PARITY_EN], stop(1).
// Latency: start bit appears on tx_out one cycle after the tx_valid/tx_ready handshake edge.
// Backpressure: tx_ready is low for the whole frame; tx_data/tx_valid are ignored until IDLE.
module serial_tx
  import serial_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx_out,
  output logic              tx_busy
);

  localparam int BC_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(DATA_W - 1);

  state_t            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic              tx_out_q, tx_out_d;
  logic              tx_ready_q, tx_ready_d;
  logic              tx_busy_q, tx_busy_d;
  logic              tick;
`ifdef SERIAL_TX_PARITY_EN
  logic              parity_q, parity_d;
`endif

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(state_q != ST_IDLE),
    .tick  (tick)
  );

  // Frame sequencing plus the registered line/handshake outputs for the next cycle.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
`ifdef SERIAL_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (tx_valid && tx_ready_q) begin
          shreg_d   = tx_data;
          bit_cnt_d = '0;
          state_d   = ST_START;
`ifdef SERIAL_TX_PARITY_EN
          parity_d  = ^tx_data;
`endif
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (tick) begin
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
`ifdef SERIAL_TX_PARITY_EN
            state_d   = ST_PARITY;
`else
            state_d   = ST_STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
            shreg_d   = shreg_q >> 1;
          end
        end
      end
      ST_PARITY: begin
`ifdef SERIAL_TX_PARITY_EN
        if (tick) state_d = ST_STOP;
`else
        state_d = ST_IDLE;
`endif
      end
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they are registered yet cycle-aligned.
    tx_out_d   = LINE_IDLE;
    tx_ready_d = (state_d == ST_IDLE);
    tx_busy_d  = (state_d != ST_IDLE);
    case (state_d)
      ST_START:  tx_out_d = START_BIT;
      ST_DATA:   tx_out_d = shreg_d[0];
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: tx_out_d = parity_d;
`endif
      ST_STOP:   tx_out_d = STOP_BIT;
      default:   tx_out_d = LINE_IDLE;
    endcase
  end

  // State and output registers; reset drives the line idle-high immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      tx_out_q   <= LINE_IDLE;
      tx_ready_q <= 1'b1;
      tx_busy_q  <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      tx_out_q   <= tx_out_d;
      tx_ready_q <= tx_ready_d;
      tx_busy_q  <= tx_busy_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  assign tx_out   = tx_out_q;
  assign tx_ready = tx_ready_q;
  assign tx_busy  = tx_busy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Directed bench for serial_tx: DATA_W=8/CLKS_PER_BIT=4 main instance plus a DATA_W=4/CLKS_PER_BIT=1 instance.
// Inputs are driven and outputs sampled on the falling clock edge.
// Expected line sequences are hand-written frame vectors, bit i of a vector is serial bit i.
module tb_serial_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid, tx_ready, tx_out, tx_busy;
  logic [3:0] s_data;
  logic       s_valid, s_ready, s_out, s_busy;

  int checks   = 0;
  int failures = 0;

`ifdef SERIAL_TX_PARITY_EN
  localparam int NB   = 11;
  localparam int NB_S = 7;
  localparam logic [15:0] F_A5 = 16'b10101001010;
  localparam logic [15:0] F_3C = 16'b10001111000;
  localparam logic [15:0] F_00 = 16'b10000000000;
  localparam logic [15:0] F_FF = 16'b10111111110;
  localparam logic [15:0] F_81 = 16'b10100000010;
  localparam logic [15:0] F_01 = 16'b11000000010;
  localparam logic [15:0] F_S9 = 16'b1010010;
`else
  localparam int NB   = 10;
  localparam int NB_S = 6;
  localparam logic [15:0] F_A5 = 16'b1101001010;
  localparam logic [15:0] F_3C = 16'b1001111000;
  localparam logic [15:0] F_00 = 16'b1000000000;
  localparam logic [15:0] F_FF = 16'b1111111110;
  localparam logic [15:0] F_81 = 16'b1100000010;
  localparam logic [15:0] F_01 = 16'b1000000010;
  localparam logic [15:0] F_S9 = 16'b110010;
`endif
  localparam int FL = NB * 4;

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .tx_out(tx_out), .tx_busy(tx_busy)
  );

  serial_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .tx_data(s_data), .tx_valid(s_valid),
    .tx_ready(s_ready), .tx_out(s_out), .tx_busy(s_busy)
  );

  // Offer one word for exactly one handshake edge; returns on the first falling edge of the frame.
  task automatic start_frame(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tx_valid = 1'b0; tx_data = '0; s_valid = 1'b0; s_data = '0;
    repeat (2) @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_state out/ready/busy=%b%b%b expected=110", tx_out, tx_ready, tx_busy);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release out/ready/busy=%b%b%b expected=110", tx_out, tx_ready, tx_busy);
    end
  endtask

  task automatic test_single();
    logic [15:0] exp;
    exp = F_A5;
    start_frame(8'hA5);
    for (int c = 0; c < FL; c++) begin
      checks++;
      if (tx_out !== exp[c/4]) begin
        failures++;
        $display("FAIL single_bit cycle=%0d tx_out=%b expected=%b", c, tx_out, exp[c/4]);
      end
      checks++;
      if (tx_ready !== 1'b0 || tx_busy !== 1'b1) begin
        failures++;
        $display("FAIL single_hs cycle=%0d ready/busy=%b%b expected=01", c, tx_ready, tx_busy);
      end
      @(negedge clk);
    end
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL single_end out/ready/busy=%b%b%b expected=110", tx_out, tx_ready, tx_busy);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] e1, e2;
    logic        eb, er;
    e1 = F_00;
    e2 = F_FF;
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'hFF;
    for (int c = 0; c <= 2 * FL; c++) begin
      if (c < FL) begin
        eb = e1[c/4]; er = 1'b0;
      end else if (c == FL) begin
        eb = 1'b1;    er = 1'b1;
      end else begin
        eb = e2[(c-FL-1)/4]; er = 1'b0;
      end
      checks++;
      if (tx_out !== eb) begin
        failures++;
        $display("FAIL b2b_bit cycle=%0d tx_out=%b expected=%b", c, tx_out, eb);
      end
      checks++;
      if (tx_ready !== er) begin
        failures++;
        $display("FAIL b2b_ready cycle=%0d tx_ready=%b expected=%b", c, tx_ready, er);
      end
      if (c == FL + 1) tx_valid = 1'b0;
      @(negedge clk);
    end
    checks++;
    if (tx_ready !== 1'b1 || tx_busy !== 1'b0 || tx_out !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end out/ready/busy=%b%b%b expected=110", tx_out, tx_ready, tx_busy);
    end
  endtask

  task automatic test_stability();
    logic [15:0] exp;
    exp = F_81;
    start_frame(8'h81);
    for (int c = 0; c < FL; c++) begin
      if (c == 5)  tx_data  = 8'h00;
      if (c == 20) tx_valid = 1'b1;
      if (c == 23) tx_valid = 1'b0;
      checks++;
      if (tx_out !== exp[c/4]) begin
        failures++;
        $display("FAIL stable_bit cycle=%0d tx_out=%b expected=%b", c, tx_out, exp[c/4]);
      end
      @(negedge clk);
    end
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (tx_busy !== 1'b0 || tx_out !== 1'b1 || tx_ready !== 1'b1) begin
        failures++;
        $display("FAIL stable_idle cycle=%0d out/ready/busy=%b%b%b expected=110", c, tx_out, tx_ready, tx_busy);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midframe();
    logic [15:0] exp;
    start_frame(8'hA5);
    repeat (10) @(negedge clk);
    checks++;
    if (tx_out !== 1'b0 || tx_busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre out/busy=%b%b expected=01", tx_out, tx_busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (tx_out !== 1'b1 || tx_ready !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_async out/ready/busy=%b%b%b expected=110", tx_out, tx_ready, tx_busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (tx_out !== 1'b1 || tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_noresume out/busy=%b%b expected=10", tx_out, tx_busy);
    end
    exp = F_3C;
    start_frame(8'h3C);
    for (int c = 0; c < FL; c++) begin
      checks++;
      if (tx_out !== exp[c/4] || tx_busy !== 1'b1) begin
        failures++;
        $display("FAIL post_reset_bit cycle=%0d out/busy=%b%b expected=%b1", c, tx_out, tx_busy, exp[c/4]);
      end
      @(negedge clk);
    end
    checks++;
    if (tx_busy !== 1'b0 || tx_ready !== 1'b1) begin
      failures++;
      $display("FAIL post_reset_end ready/busy=%b%b expected=10", tx_ready, tx_busy);
    end
  endtask

  task automatic test_parity();
    logic [15:0] exp;
    exp = F_01;
    start_frame(8'h01);
    for (int c = 0; c < FL; c++) begin
      checks++;
      if (tx_out !== exp[c/4]) begin
        failures++;
        $display("FAIL parity_bit cycle=%0d tx_out=%b expected=%b", c, tx_out, exp[c/4]);
      end
      @(negedge clk);
    end
    checks++;
    if (tx_busy !== 1'b0) begin
      failures++;
      $display("FAIL parity_len busy=%b expected=0 after %0d cycles", tx_busy, FL);
    end
  endtask

  task automatic test_small();
    logic [15:0] exp;
    exp = F_S9;
    s_data  = 4'h9;
    s_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    s_valid = 1'b0;
    for (int c = 0; c < NB_S; c++) begin
      checks++;
      if (s_out !== exp[c] || s_busy !== 1'b1) begin
        failures++;
        $display("FAIL small_bit cycle=%0d out/busy=%b%b expected=%b1", c, s_out, s_busy, exp[c]);
      end
      @(negedge clk);
    end
    checks++;
    if (s_busy !== 1'b0 || s_out !== 1'b1 || s_ready !== 1'b1) begin
      failures++;
      $display("FAIL small_end out/ready/busy=%b%b%b expected=110", s_out, s_ready, s_busy);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stability();
    test_reset_midframe();
    test_parity();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
